// File: rtl/regex_imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: the return tag carried alongside each read.
package regex_imem_arbiter_pkg;

  localparam int MAX_MEM_LATENCY = 4;
  localparam int MAX_N_CPU       = 16;

  // Sized for the largest CPU array so one tag type serves every configuration.
  localparam int TAG_ID_W = $clog2(MAX_N_CPU);

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } imem_tag_t;

  localparam imem_tag_t EMPTY_TAG = '{valid: 1'b0, id: '0};

endpackage

// File: rtl/regex_imem_arbiter_rr_picker.sv
// Round-robin picker: rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
module regex_rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             found,
  output logic [PTR_W-1:0] winner,
  output logic [N-1:0]     grant
);

  logic [2*N-1:0]   doubled;
  logic [N-1:0]     rotated;
  logic [PTR_W-1:0] offset;

  assign doubled = {req, req};
  assign rotated = doubled[int'(ptr) +: N];

  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        found  = 1'b1;
        offset = PTR_W'(k);
      end
    end
  end

  always_comb begin
    int sum;
    sum = int'(ptr) + int'(offset);
    if (sum >= N) begin
      sum = sum - N;
    end
    winner = PTR_W'(sum);
  end

  assign grant = found ? (N'(1) << winner) : '0;

endmodule

// File: rtl/regex_imem_arbiter.sv
// Round-robin sharing of one synchronous-read instruction RAM among N_CPU regex CPUs,
// one grant per cycle, with a tag pipeline matching the RAM latency to route returns.
module regex_imem_arbiter
  import regex_imem_arbiter_pkg::*;
#(
  parameter int N_CPU             = 4,
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEM_LATENCY       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_CPU-1:0]                     cpu_memory_valid,
  input  logic [N_CPU*MEMORY_ADDR_WIDTH-1:0]   cpu_memory_addr,
  output logic [N_CPU-1:0]                     cpu_memory_ready,
  output logic [MEMORY_WIDTH-1:0]              cpu_memory_data,
  output logic                                 ram_rd_en,
  output logic [MEMORY_ADDR_WIDTH-1:0]         ram_rd_addr,
  input  logic [MEMORY_WIDTH-1:0]              ram_rd_data,
  output logic                                 busy
);

  localparam int PTR_W = $clog2(N_CPU);

  if (N_CPU < 2 || N_CPU > MAX_N_CPU) begin : g_bad_n_cpu
    $error("N_CPU out of range");
  end
  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_bad_latency
    $error("MEM_LATENCY out of range");
  end

  logic [PTR_W-1:0]             rr_ptr;
  logic [N_CPU-1:0]             inflight;
  logic                         post_rst;
  imem_tag_t                    tag_p [MEM_LATENCY];
  logic [MEMORY_ADDR_WIDTH-1:0] last_addr;

  logic [N_CPU-1:0]             eligible;
  logic                         found;
  logic [PTR_W-1:0]             winner;
  logic [N_CPU-1:0]             grant;
  logic                         issue;
  logic [N_CPU-1:0]             issue_mask;
  logic [MEMORY_ADDR_WIDTH-1:0] addr_sel;
  imem_tag_t                    new_tag;
  imem_tag_t                    ret_tag;
  logic [N_CPU-1:0]             ret_mask;
  logic [PTR_W-1:0]             next_ptr;

  // An in-flight CPU is masked out, so its valid is never re-sampled until the return retires.
  assign eligible = cpu_memory_valid & ~inflight;

  regex_rr_picker #(
    .N     (N_CPU),
    .PTR_W (PTR_W)
  ) u_picker (
    .req    (eligible),
    .ptr    (rr_ptr),
    .found  (found),
    .winner (winner),
    .grant  (grant)
  );

  // Issue is held off during reset and in the cycle that follows it.
  assign issue      = found & ~rst & ~post_rst;
  assign issue_mask = issue ? grant : '0;
  assign addr_sel   = cpu_memory_addr[int'(winner)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
  assign next_ptr   = (int'(winner) == N_CPU - 1) ? '0 : winner + 1'b1;

  always_comb begin
    new_tag = EMPTY_TAG;
    if (issue) begin
      new_tag.valid = 1'b1;
      new_tag.id    = TAG_ID_W'(winner);
    end
  end

  assign ret_tag  = tag_p[MEM_LATENCY-1];
  assign ret_mask = (ret_tag.valid && !rst) ? (N_CPU'(1) << ret_tag.id) : '0;

  // Stage p0: grant, tag entry and in-flight bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      inflight <= '0;
      post_rst <= 1'b1;
      for (int k = 0; k < MEM_LATENCY; k++) begin
        tag_p[k] <= EMPTY_TAG;
      end
    end else begin
      post_rst <= 1'b0;
      inflight <= (inflight | issue_mask) & ~ret_mask;
      if (issue) begin
        rr_ptr <= next_ptr;
      end
      tag_p[0] <= new_tag;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        tag_p[k] <= tag_p[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      last_addr <= addr_sel;
    end
  end

  assign ram_rd_en   = issue;
  assign ram_rd_addr = issue ? addr_sel : last_addr;

  // Stage pN (N = MEM_LATENCY): RAM word returns to the tagged CPU
  assign cpu_memory_ready = ret_mask;
  assign cpu_memory_data  = ram_rd_data;
  assign busy             = (|inflight) & ~rst;

  ready_onehot_a : assert property (@(posedge clk) disable iff (rst) $onehot0(cpu_memory_ready));

endmodule

// File: tb/tb_regex_imem_arbiter.sv
// Bench for regex_imem_arbiter: one instance at MEM_LATENCY=1 and one at MEM_LATENCY=3.
module tb_regex_imem_arbiter;

  localparam int N  = 4;
  localparam int DW = 20;
  localparam int AW = 11;

  typedef struct {
    logic [N-1:0]  rdy;
    logic [DW-1:0] data;
  } ret_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic            rst_a, rst_b;
  logic [N-1:0]    va, vb, ra, rb;
  logic [N*AW-1:0] aa, ab;
  logic [DW-1:0]   da, db, ramda, ramdb;
  logic            ena, enb, busya, busyb;
  logic [AW-1:0]   rda, rdb;

  logic [AW-1:0] qga[$];
  logic [AW-1:0] qgb[$];
  ret_t          qra[$];
  ret_t          qrb[$];
  ret_t          ea, eb;

  regex_imem_arbiter #(.N_CPU(N), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst_a), .cpu_memory_valid(va), .cpu_memory_addr(aa),
    .cpu_memory_ready(ra), .cpu_memory_data(da), .ram_rd_en(ena), .ram_rd_addr(rda),
    .ram_rd_data(ramda), .busy(busya));

  regex_imem_arbiter #(.N_CPU(N), .MEMORY_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst_b), .cpu_memory_valid(vb), .cpu_memory_addr(ab),
    .cpu_memory_ready(rb), .cpu_memory_data(db), .ram_rd_en(enb), .ram_rd_addr(rdb),
    .ram_rd_data(ramdb), .busy(busyb));

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 11'h06E) return 20'h12345;
    return {a[8:0], a} ^ 20'h5A5A5;
  endfunction

  // RAM models with the two read latencies
  logic [AW-1:0] ram_a_p0;
  logic [AW-1:0] ram_b_p [3];
  always @(posedge clk) begin
    ram_a_p0   <= rda;
    ram_b_p[0] <= rdb;
    ram_b_p[1] <= ram_b_p[0];
    ram_b_p[2] <= ram_b_p[1];
  end
  assign ramda = mem_val(ram_a_p0);
  assign ramdb = mem_val(ram_b_p[2]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, required no event (t=%0t)", name, act, $time);
  endtask

  task automatic exp_a(input int cpu, input logic [AW-1:0] addr, input bit with_ret);
    qga.push_back(addr);
    if (with_ret) qra.push_back('{rdy: N'(1) << cpu, data: mem_val(addr)});
  endtask

  task automatic exp_b(input int cpu, input logic [AW-1:0] addr);
    qgb.push_back(addr);
    qrb.push_back('{rdy: N'(1) << cpu, data: mem_val(addr)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Monitors: every grant and every ready pulse is matched against the queues
  always @(negedge clk) begin
    if (rst_a === 1'b0) begin
      if (ena === 1'b1) begin
        if (qga.size() == 0) unexpected("a_grant_unexpected", 32'(rda));
        else chk("a_grant_addr", 32'(rda), 32'(qga.pop_front()));
      end
      if (ra !== '0) begin
        chk("a_ready_onehot", 32'($onehot(ra)), 32'd1);
        if (qra.size() == 0) unexpected("a_ready_unexpected", 32'(ra));
        else begin
          ea = qra.pop_front();
          chk("a_ready_cpu", 32'(ra), 32'(ea.rdy));
          chk("a_ready_data", 32'(da), 32'(ea.data));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b === 1'b0) begin
      if (enb === 1'b1) begin
        if (qgb.size() == 0) unexpected("b_grant_unexpected", 32'(rdb));
        else chk("b_grant_addr", 32'(rdb), 32'(qgb.pop_front()));
      end
      if (rb !== '0) begin
        chk("b_ready_onehot", 32'($onehot(rb)), 32'd1);
        if (qrb.size() == 0) unexpected("b_ready_unexpected", 32'(rb));
        else begin
          eb = qrb.pop_front();
          chk("b_ready_cpu", 32'(rb), 32'(eb.rdy));
          chk("b_ready_data", 32'(db), 32'(eb.data));
        end
      end
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    va = '1; vb = '0; aa = '0; ab = '0;

    // Single request right after reset, valid already high during reset
    tick; tick; samp;
    chk("rst_en", 32'(ena), 0); chk("rst_ready", 32'(ra), 0); chk("rst_busy", 32'(busya), 0);
    tick;
    rst_a = 1'b0; va = 4'b0001; aa[0*AW +: AW] = 11'h06E;
    exp_a(0, 11'h06E, 1);
    samp; chk("post_rst_en", 32'(ena), 0); chk("post_rst_busy", 32'(busya), 0);
    tick; samp; chk("t1_grant_en", 32'(ena), 1); chk("t1_grant_addr", 32'(rda), 32'h06E);
    tick; samp;
    chk("t1_ready", 32'(ra), 32'b0001); chk("t1_data", 32'(da), 32'h12345);
    chk("t1_no_regrant", 32'(ena), 0); chk("t1_busy", 32'(busya), 1);
    tick; va = 4'b0000;
    tick; samp; chk("t1_idle_busy", 32'(busya), 0); chk("t1_hold_addr", 32'(rda), 32'h06E);

    // All four CPUs requesting continuously from rr_ptr=0
    tick; rst_a = 1'b1;
    tick; rst_a = 1'b0; va = 4'b1111;
    for (int i = 0; i < N; i++) aa[i*AW +: AW] = AW'(11'h100 + i);
    for (int k = 0; k < 12; k++) exp_a(k % 4, AW'(11'h100 + k % 4), 1);
    for (int k = 0; k < 15; k++) begin
      if (k == 13) va = 4'b1000;
      if (k == 14) va = 4'b0000;
      samp;
      chk("t2_en", 32'(ena), 32'(k >= 1 && k <= 12));
      chk("t2_ready", 32'(ra), (k >= 2 && k <= 13) ? 32'(1 << ((k - 2) % 4)) : 32'd0);
      tick;
    end

    // rr_ptr=2 with CPUs 1 and 3 requesting: CPU3 wins first
    va = 4'b0010; aa[1*AW +: AW] = 11'h201; aa[3*AW +: AW] = 11'h203;
    exp_a(1, 11'h201, 1); exp_a(3, 11'h203, 1); exp_a(1, 11'h201, 1);
    samp; chk("t3_setup_grant", 32'(rda), 32'h201);
    tick; va = 4'b0000;
    tick; va = 4'b1010;
    samp; chk("t3_ptr2_en", 32'(ena), 1); chk("t3_ptr2_pick3", 32'(rda), 32'h203);
    tick; samp; chk("t3_then1", 32'(rda), 32'h201); chk("t3_ready3", 32'(ra), 32'b1000);
    tick; va = 4'b0010;
    samp; chk("t3_ready1", 32'(ra), 32'b0010); chk("t3_no_regrant", 32'(ena), 0);
    tick; va = 4'b0000;
    tick; samp; chk("t3_hold_addr", 32'(rda), 32'h201); chk("t3_idle_en", 32'(ena), 0);

    // Reset one cycle after two grants: the second return is dropped
    tick;
    va = 4'b0101; aa[0*AW +: AW] = 11'h050; aa[2*AW +: AW] = 11'h052;
    exp_a(2, 11'h052, 1); exp_a(0, 11'h050, 0);
    tick; samp; chk("t5_ready2", 32'(ra), 32'b0100);
    tick; rst_a = 1'b1;
    tick; rst_a = 1'b0;
    samp;
    chk("t5_post_ready", 32'(ra), 0); chk("t5_post_en", 32'(ena), 0); chk("t5_post_busy", 32'(busya), 0);
    exp_a(0, 11'h050, 1); exp_a(2, 11'h052, 1);
    tick; samp; chk("t5_lowest_first", 32'(rda), 32'h050);
    tick; samp; chk("t5_ready0", 32'(ra), 32'b0001);
    tick; va = 4'b0100;
    samp; chk("t5_ready2_again", 32'(ra), 32'b0100); chk("t5_no_regrant", 32'(ena), 0);
    tick; va = 4'b0000;
    tick; tick;

    // MEM_LATENCY=3, CPUs 0 and 2 requesting
    rst_b = 1'b0; vb = 4'b0101;
    ab[0*AW +: AW] = 11'h300; ab[2*AW +: AW] = 11'h302;
    for (int k = 0; k < 6; k++) exp_b((k % 2) * 2, AW'(11'h300 + (k % 2) * 2));
    for (int k = 0; k < 16; k++) begin
      if (k == 13) vb = 4'b0100;
      if (k == 14) vb = 4'b0000;
      samp;
      chk("t4_en", 32'(enb), 32'(k >= 1 && k <= 10 && (k % 4 == 1 || k % 4 == 2)));
      chk("t4_ready", 32'(rb),
          (k >= 4 && k <= 13 && k % 4 == 0) ? 32'b0001 :
          (k >= 5 && k <= 13 && k % 4 == 1) ? 32'b0100 : 32'd0);
      chk("t4_busy", 32'(busyb), 32'(k >= 2 && k <= 13));
      tick;
    end

    repeat (3) tick;
    chk("a_grants_left", 32'(qga.size()), 0);
    chk("a_returns_left", 32'(qra.size()), 0);
    chk("b_grants_left", 32'(qgb.size()), 0);
    chk("b_returns_left", 32'(qrb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
